// File: rtl/dmem_resp.sv
// Data-memory responder: serves mem_in_type requests from an internal byte-strobed RAM
// with a fixed, parameterised response latency and pipelined acceptance in the ready cycle.
package dmem_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned mem_depth   = 12,
    parameter logic [31:0] mem_base    = 32'h0,
    parameter int unsigned mem_latency = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out
);

    localparam int unsigned words    = 2 ** mem_depth;
    localparam logic [32:0] span     = 33'(1) << (mem_depth + 2);
    localparam logic [3:0]  cnt_load = (mem_latency > 1) ? 4'(mem_latency - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] data_q;
    mem_out_type out_q;
    logic        ready_nxt;
    logic [31:0] rdata_nxt;

    logic [31:0] ram [words];

    logic                 accept;
    logic [31:0]          off;
    logic                 in_range;
    logic [mem_depth-1:0] idx;
    logic                 is_write;
    logic                 is_read;
    logic [31:0]          cap_data;
    logic                 unused_instr;

    // Request decode; new requests are only sampled when not counting latency.
    assign accept   = dmem_in.mem_valid && (state == IDLE || state == RESP);
    assign off      = dmem_in.mem_addr - mem_base;
    assign in_range = (dmem_in.mem_addr >= mem_base) && ({1'b0, off} < span);
    assign idx      = off[mem_depth+1:2];
    assign is_write = accept && !dmem_in.mem_fence && in_range && (dmem_in.mem_wstrb != 4'h0);
    assign is_read  = accept && !dmem_in.mem_fence && in_range && (dmem_in.mem_wstrb == 4'h0);
    assign cap_data = is_read ? ram[idx] : 32'h0;
    assign unused_instr = dmem_in.mem_instr;

    // Next-state and response staging.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = 1'b0;
        rdata_nxt = 32'h0;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (mem_latency == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = cnt_load;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == RESP) begin
            ready_nxt = 1'b1;
            rdata_nxt = accept ? cap_data : data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            data_q <= 32'h0;
            out_q  <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            out_q.mem_ready <= ready_nxt;
            out_q.mem_rdata <= rdata_nxt;
            if (accept) begin
                data_q <= cap_data;
            end
        end
    end

    // RAM contents survive reset; writes commit at the accept edge.
    always_ff @(posedge clock) begin
        if (reset && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_in.mem_wstrb[i]) begin
                    ram[idx][8*i +: 8] <= dmem_in.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_out = out_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: four instances cover L=2, L=1, offset base/small RAM and L=4.
module tb_dmem_resp;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst [4];
    mem_in_type  din [4];
    mem_out_type dout[4];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_resp #(.mem_depth(12), .mem_base(32'h0),    .mem_latency(2)) u_l2
        (.clock(clk), .reset(rst[0]), .dmem_in(din[0]), .dmem_out(dout[0]));
    dmem_resp #(.mem_depth(12), .mem_base(32'h0),    .mem_latency(1)) u_l1
        (.clock(clk), .reset(rst[1]), .dmem_in(din[1]), .dmem_out(dout[1]));
    dmem_resp #(.mem_depth(4),  .mem_base(32'h1000), .mem_latency(2)) u_oor
        (.clock(clk), .reset(rst[2]), .dmem_in(din[2]), .dmem_out(dout[2]));
    dmem_resp #(.mem_depth(12), .mem_base(32'h0),    .mem_latency(4)) u_l4
        (.clock(clk), .reset(rst[3]), .dmem_in(din[3]), .dmem_out(dout[3]));

    // Drives one request from a negedge and waits (bounded) for its ready; lat=0 means timeout.
    task automatic issue(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic fence,
                         output logic [31:0] rdata, output int lat);
        din[k].mem_valid = 1'b1;
        din[k].mem_fence = fence;
        din[k].mem_instr = 1'b0;
        din[k].mem_addr  = addr;
        din[k].mem_wdata = wdata;
        din[k].mem_wstrb = wstrb;
        lat   = 0;
        rdata = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dout[k].mem_ready) begin
                lat   = c;
                rdata = dout[k].mem_rdata;
                break;
            end
        end
        din[k].mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b0;
            din[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dout[k].mem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got %b expected 0", k, dout[k].mem_ready);
            end
            n_checks++;
            if (dout[k].mem_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata[%0d]: got %h expected 0", k, dout[k].mem_rdata);
            end
        end
        for (int k = 0; k < 4; k++) rst[k] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd, e;
        int lat;
        logic [31:0] addr_t [3] = '{32'h10, 32'h10, 32'h10};
        logic [31:0] wd_t   [3] = '{32'hAABBCCDD, 32'h11223344, 32'h0};
        logic [3:0]  ws_t   [3] = '{4'hF, 4'b0101, 4'h0};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hAA22CC44);
        for (int i = 0; i < 3; i++) begin
            issue(0, addr_t[i], wd_t[i], ws_t[i], 1'b0, rd, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (rd !== e) begin
                n_fail++;
                $display("FAIL wr_rd_data[%0d]: got %h expected %h", i, rd, e);
            end
            n_checks++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL wr_rd_latency[%0d]: got %0d expected 2", i, lat);
            end
        end
    endtask

    task automatic test_burst();
        logic [31:0] rd, e;
        int lat, beats, extra;
        for (int i = 0; i < 4; i++) issue(0, 32'h20 + 32'(4 * i), 32'(i + 1), 4'hF, 1'b0, rd, lat);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
        din[0].mem_valid = 1'b1;
        din[0].mem_fence = 1'b0;
        din[0].mem_addr  = 32'h20;
        din[0].mem_wdata = 32'h0;
        din[0].mem_wstrb = 4'h0;
        beats = 0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dout[0].mem_ready) begin
                beats++;
                e = exp_q.pop_front();
                n_checks++;
                if (dout[0].mem_rdata !== e) begin
                    n_fail++;
                    $display("FAIL burst_data[%0d]: got %h expected %h", beats, dout[0].mem_rdata, e);
                end
                n_checks++;
                if (c != 2 * beats) begin
                    n_fail++;
                    $display("FAIL burst_cycle[%0d]: got %0d expected %0d", beats, c, 2 * beats);
                end
                if (beats == 4) begin
                    din[0].mem_valid = 1'b0;
                    break;
                end
                din[0].mem_addr = din[0].mem_addr + 32'd4;
            end
        end
        n_checks++;
        if (beats != 4) begin
            n_fail++;
            $display("FAIL burst_beats: got %0d expected 4", beats);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (dout[0].mem_ready) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL burst_idle: got %0d extra readies expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, e;
        int lat, beats, badlat;
        badlat = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i * 3), 4'hF, 1'b0, rd, lat);
            if (lat != 1) badlat++;
        end
        n_checks++;
        if (badlat != 0) begin
            n_fail++;
            $display("FAIL b2b_preload_latency: got %0d bad latencies expected 0", badlat);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE0000 + 32'(i * 3));
        din[1].mem_valid = 1'b1;
        din[1].mem_fence = 1'b0;
        din[1].mem_addr  = 32'h40;
        din[1].mem_wstrb = 4'h0;
        beats = 0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dout[1].mem_ready) begin
                beats++;
                e = exp_q.pop_front();
                n_checks++;
                if (dout[1].mem_rdata !== e || c != beats) begin
                    n_fail++;
                    $display("FAIL b2b_beat[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             beats, dout[1].mem_rdata, c, e, beats);
                end
                if (beats == 8) begin
                    din[1].mem_valid = 1'b0;
                    break;
                end
                din[1].mem_addr = din[1].mem_addr + 32'd4;
            end
        end
        @(negedge clk);
        n_checks++;
        if (beats != 8 || dout[1].mem_ready !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats, trailing ready %b, queue %0d expected 8, 0, 0",
                     beats, dout[1].mem_ready, exp_q.size());
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, e, sum_got, sum_exp;
        int lat;
        sum_exp = 32'h0;
        for (int i = 0; i < 16; i++) begin
            issue(2, 32'h1000 + 32'(4 * i), 32'h10000000 + 32'(i * 32'h0101), 4'hF, 1'b0, rd, lat);
            sum_exp = sum_exp + 32'h10000000 + 32'(i * 32'h0101);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        issue(2, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e || lat != 2) begin
            n_fail++;
            $display("FAIL oor_wr_low: got %h lat %0d expected %h lat 2", rd, lat, e);
        end
        issue(2, 32'h1040, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e || lat != 2) begin
            n_fail++;
            $display("FAIL oor_wr_high: got %h lat %0d expected %h lat 2", rd, lat, e);
        end
        issue(2, 32'h1040, 32'h0, 4'h0, 1'b0, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e || lat != 2) begin
            n_fail++;
            $display("FAIL oor_rd: got %h lat %0d expected %h lat 2", rd, lat, e);
        end
        sum_got = 32'h0;
        for (int i = 0; i < 16; i++) begin
            issue(2, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, 1'b0, rd, lat);
            sum_got = sum_got + rd;
        end
        n_checks++;
        if (sum_got !== sum_exp) begin
            n_fail++;
            $display("FAIL oor_checksum: got %h expected %h", sum_got, sum_exp);
        end
    endtask

    task automatic test_fence();
        logic [31:0] rd, e;
        int lat;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h10000000);
        issue(2, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e || lat != 2) begin
            n_fail++;
            $display("FAIL fence_resp: got %h lat %0d expected %h lat 2", rd, lat, e);
        end
        issue(2, 32'h1000, 32'h0, 4'h0, 1'b0, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e) begin
            n_fail++;
            $display("FAIL fence_word0: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e;
        int lat, bad;
        din[3].mem_valid = 1'b1;
        din[3].mem_fence = 1'b0;
        din[3].mem_addr  = 32'h8;
        din[3].mem_wdata = 32'h5A5A5A5A;
        din[3].mem_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        din[3].mem_valid = 1'b0;
        rst[3] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[3] = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (dout[3].mem_ready !== 1'b0 || dout[3].mem_rdata !== 32'h0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d nonzero output cycles expected 0", bad);
        end
        // A request present only during the reset cycle must be dropped.
        rst[3] = 1'b0;
        din[3].mem_valid = 1'b1;
        din[3].mem_wstrb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        rst[3] = 1'b1;
        din[3].mem_valid = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (dout[3].mem_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_valid_dropped: got %0d readies expected 0", bad);
        end
        exp_q.push_back(32'h5A5A5A5A);
        issue(3, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e || lat != 4) begin
            n_fail++;
            $display("FAIL rst_write_persist: got %h lat %0d expected %h lat 4", rd, lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_back_to_back();
        test_out_of_range();
        test_fence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
